ex_dispatch_arbiter: RTL and testbench

Generates the one-hot `ALU_Grt` / `MEM_Grt` grant vectors that steer the four operand collectors onto the ALU and MEM execution ports, and releases each collector once it has been dispatched. It sits between the operand collectors and the ALU/MEM dispatch mux. Each grant takes one cycle to go out. Both units use round-robin fairness. MEM issue is credit-based, and the ALU has a stall input.

---
 rtl/ex_dispatch_pkg.sv | 20 ++
 rtl/ex_dispatch_arbiter_rr_pick4.sv | 27 ++
 rtl/ex_dispatch_arbiter.sv | 114 +++++++++++
 tb/tb_ex_dispatch_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_dispatch_pkg.sv
// Shared types and constants for the execute-stage dispatch arbiter.
package ex_dispatch_pkg;

    localparam int NUM_OC      = 4;
    localparam int MEM_CREDITS = 2;

    typedef logic [3:0] oc_vec_t;
    typedef logic [1:0] rr_ptr_t;

    // Index of the set bit in a one-hot collector vector (0 when empty).
    function automatic rr_ptr_t oh_to_idx(input oc_vec_t oh);
        rr_ptr_t idx;
        idx = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (oh[i]) idx = rr_ptr_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ex_dispatch_arbiter_rr_pick4.sv
// Four-way round-robin picker: first requester at or above ptr, wrapping.
module rr_pick4
    import ex_dispatch_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       any
);

    rr_ptr_t idx;

    // Walk the four positions starting at ptr; the first hit wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = ptr;
        for (int k = 0; k < NUM_OC; k++) begin
            idx = ptr + rr_ptr_t'(k);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_dispatch_arbiter.sv
// Steers ready operand collectors onto the ALU and MEM ports with
// round-robin fairness, a stallable ALU and a credit-limited MEM port.
//
// Handshake: OC_Ready[i] is a level request held until the collector sees
// OC_Release[i]; the release is the registered grant itself, so a grant
// on the outputs for one cycle is the complete transfer for collector i.
module ex_dispatch_arbiter
    import ex_dispatch_pkg::*;
#(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    OC_Ready,
    input  logic [3:0]    OC_IsMem,
    input  logic          ALU_Stall,
    input  logic          MEM_Done,
    output logic [3:0]    ALU_Grt,
    output logic [3:0]    MEM_Grt,
    output logic [3:0]    OC_Release,
    output logic [CW-1:0] Mem_Credits,
    output logic          Credit_Err
);

    oc_vec_t       alu_grt_q, alu_grt_d;
    oc_vec_t       mem_grt_q, mem_grt_d;
    rr_ptr_t       alu_ptr_q, alu_ptr_d;
    rr_ptr_t       mem_ptr_q, mem_ptr_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    oc_vec_t inflight, alu_req, mem_req, alu_pick, mem_pick;
    logic    alu_any, mem_any, alu_fire, mem_fire, credits_full;

    // A collector whose grant is on the outputs is still releasing; mask it.
    assign inflight = alu_grt_q | mem_grt_q;
    assign alu_req  = OC_Ready & ~OC_IsMem & ~inflight;
    assign mem_req  = OC_Ready &  OC_IsMem & ~inflight;

    rr_pick4 u_alu_pick (
        .req (alu_req),
        .ptr (alu_ptr_q),
        .gnt (alu_pick),
        .any (alu_any)
    );

    rr_pick4 u_mem_pick (
        .req (mem_req),
        .ptr (mem_ptr_q),
        .gnt (mem_pick),
        .any (mem_any)
    );

    assign alu_fire     = ~ALU_Stall & alu_any;
    assign mem_fire     = (credits_q != '0) & mem_any;
    assign credits_full = (credits_q == CW'(MEM_CREDITS));

    // Next grants and pointers; the pointer moves past the winner only on a grant.
    always_comb begin
        alu_grt_d = '0;
        mem_grt_d = '0;
        alu_ptr_d = alu_ptr_q;
        mem_ptr_d = mem_ptr_q;
        if (alu_fire) begin
            alu_grt_d = alu_pick;
            alu_ptr_d = oh_to_idx(alu_pick) + 2'd1;
        end
        if (mem_fire) begin
            mem_grt_d = mem_pick;
            mem_ptr_d = oh_to_idx(mem_pick) + 2'd1;
        end
    end

    // Credit accounting: a grant consumes one, MEM_Done returns one; a
    // return with nothing outstanding is dropped and flagged stickily.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (mem_fire && !MEM_Done) begin
            credits_d = credits_q - CW'(1);
        end else if (!mem_fire && MEM_Done && !credits_full) begin
            credits_d = credits_q + CW'(1);
        end
        if (MEM_Done && credits_full) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset drops grants at once and restores full credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_grt_q <= '0;
            mem_grt_q <= '0;
            alu_ptr_q <= '0;
            mem_ptr_q <= '0;
            credits_q <= CW'(MEM_CREDITS);
            err_q     <= 1'b0;
        end else begin
            alu_grt_q <= alu_grt_d;
            mem_grt_q <= mem_grt_d;
            alu_ptr_q <= alu_ptr_d;
            mem_ptr_q <= mem_ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign ALU_Grt     = alu_grt_q;
    assign MEM_Grt     = mem_grt_q;
    assign OC_Release  = alu_grt_q | mem_grt_q;
    assign Mem_Credits = credits_q;
    assign Credit_Err  = err_q;

endmodule

// File: tb/tb_ex_dispatch_arbiter.sv
// Bench for ex_dispatch_arbiter: directed scenarios plus randomized traffic
// checked against a cycle model of the grant rules kept here.
module tb_ex_dispatch_arbiter;
    import ex_dispatch_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] oc_ready, oc_ismem;
    logic       alu_stall, mem_done;
    logic [3:0] alu_grt, mem_grt, oc_release;
    logic [1:0] mem_credits;
    logic       credit_err;

    always #5 clk = ~clk;

    ex_dispatch_arbiter #(.CW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .OC_Ready    (oc_ready),
        .OC_IsMem    (oc_ismem),
        .ALU_Stall   (alu_stall),
        .MEM_Done    (mem_done),
        .ALU_Grt     (alu_grt),
        .MEM_Grt     (mem_grt),
        .OC_Release  (oc_release),
        .Mem_Credits (mem_credits),
        .Credit_Err  (credit_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    logic [3:0] m_alu, m_mem;
    int         m_aptr, m_mptr, m_cred;
    logic       m_err;

    task automatic model_reset();
        m_alu = '0; m_mem = '0; m_aptr = 0; m_mptr = 0;
        m_cred = MEM_CREDITS; m_err = 1'b0;
    endtask

    // What the next clock edge should produce, from the current inputs.
    task automatic model_edge();
        logic [3:0] busy, na, nm;
        int a0, p0, i;
        busy = m_alu | m_mem;
        na = '0; nm = '0;
        a0 = m_aptr; p0 = m_mptr;
        if (!alu_stall) begin
            for (int k = 0; k < 4; k++) begin
                i = (a0 + k) % 4;
                if (na == 4'b0 && oc_ready[i] && !oc_ismem[i] && !busy[i]) begin
                    na[i] = 1'b1; m_aptr = (i + 1) % 4;
                end
            end
        end
        if (m_cred > 0) begin
            for (int k = 0; k < 4; k++) begin
                i = (p0 + k) % 4;
                if (nm == 4'b0 && oc_ready[i] && oc_ismem[i] && !busy[i]) begin
                    nm[i] = 1'b1; m_mptr = (i + 1) % 4;
                end
            end
        end
        if (mem_done && m_cred == MEM_CREDITS) m_err = 1'b1;
        if (nm != 4'b0 && !mem_done) m_cred = m_cred - 1;
        else if (nm == 4'b0 && mem_done && m_cred < MEM_CREDITS) m_cred = m_cred + 1;
        m_alu = na; m_mem = nm;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Collectors drop their request once released.
    task automatic retire();
        oc_ready = oc_ready & ~(m_alu | m_mem);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; oc_ready = '0; oc_ismem = '0; alu_stall = 1'b0; mem_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n_cmp++; if (alu_grt !== 4'b0) begin n_fail++; $display("FAIL reset_alu: got %b expected 0000", alu_grt); end
        n_cmp++; if (mem_grt !== 4'b0) begin n_fail++; $display("FAIL reset_mem: got %b expected 0000", mem_grt); end
        n_cmp++; if (oc_release !== 4'b0) begin n_fail++; $display("FAIL reset_rel: got %b expected 0000", oc_release); end
        n_cmp++; if (mem_credits !== 2'd2) begin n_fail++; $display("FAIL reset_cred: got %0d expected 2", mem_credits); end
        n_cmp++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", credit_err); end
        repeat (2) begin
            step();
            n_cmp++; if ((alu_grt | mem_grt) !== 4'b0) begin n_fail++; $display("FAIL idle_grt: got %b/%b expected 0", alu_grt, mem_grt); end
        end
    endtask

    task automatic test_alu_rotation();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        oc_ready = 4'b1111; oc_ismem = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (alu_grt !== exp_seq[k] || alu_grt !== m_alu) begin n_fail++; $display("FAIL rot_alu[%0d]: got %b expected %b", k, alu_grt, exp_seq[k]); end
            n_cmp++; if (mem_grt !== 4'b0) begin n_fail++; $display("FAIL rot_mem[%0d]: got %b expected 0000", k, mem_grt); end
            retire();
        end
        step();
    endtask

    task automatic test_alu_mem_pair();
        oc_ready = 4'b0101; oc_ismem = 4'b0100;
        step();
        n_cmp++; if (alu_grt !== 4'b0001) begin n_fail++; $display("FAIL pair_alu: got %b expected 0001", alu_grt); end
        n_cmp++; if (mem_grt !== 4'b0100) begin n_fail++; $display("FAIL pair_mem: got %b expected 0100", mem_grt); end
        n_cmp++; if (oc_release !== 4'b0101) begin n_fail++; $display("FAIL pair_rel: got %b expected 0101", oc_release); end
        n_cmp++; if (mem_credits !== 2'd1) begin n_fail++; $display("FAIL pair_cred: got %0d expected 1", mem_credits); end
        retire();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        n_cmp++; if (mem_credits !== 2'd2 || m_cred != 2) begin n_fail++; $display("FAIL pair_return: got %0d expected 2", mem_credits); end
    endtask

    task automatic test_mem_credits();
        logic [3:0] exp_mem [3];
        int exp_cred [3];
        exp_mem = '{4'b0001, 4'b0010, 4'b0000};
        exp_cred = '{1, 0, 0};
        oc_ready = 4'b0111; oc_ismem = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (mem_grt !== exp_mem[k] || mem_grt !== m_mem) begin n_fail++; $display("FAIL cred_mem[%0d]: got %b expected %b", k, mem_grt, exp_mem[k]); end
            n_cmp++; if (mem_credits !== 2'(exp_cred[k])) begin n_fail++; $display("FAIL cred_cnt[%0d]: got %0d expected %0d", k, mem_credits, exp_cred[k]); end
            retire();
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        n_cmp++; if (mem_grt !== 4'b0 || mem_credits !== 2'd1) begin n_fail++; $display("FAIL cred_done: got %b/%0d expected 0000/1", mem_grt, mem_credits); end
        step();
        n_cmp++; if (mem_grt !== 4'b0100 || mem_credits !== 2'd0) begin n_fail++; $display("FAIL cred_third: got %b/%0d expected 0100/0", mem_grt, mem_credits); end
        retire();
        mem_done = 1'b1;
        repeat (2) step();
        mem_done = 1'b0;
        n_cmp++; if (mem_credits !== 2'(m_cred) || m_cred != 2) begin n_fail++; $display("FAIL cred_refill: got %0d expected 2", mem_credits); end
    endtask

    task automatic test_alu_stall();
        oc_ready = 4'b1001; oc_ismem = 4'b0000; alu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (alu_grt !== 4'b0) begin n_fail++; $display("FAIL stall_alu[%0d]: got %b expected 0000", k, alu_grt); end
        end
        alu_stall = 1'b0;
        step();
        n_cmp++; if (alu_grt !== 4'b1000 || alu_grt !== m_alu) begin n_fail++; $display("FAIL stall_resume: got %b expected 1000", alu_grt); end
        retire();
        step();
        n_cmp++; if (alu_grt !== 4'b0001) begin n_fail++; $display("FAIL stall_next: got %b expected 0001", alu_grt); end
        retire();
        step();
    endtask

    task automatic test_credit_err();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        n_cmp++; if (credit_err !== 1'b1 || mem_credits !== 2'd2) begin n_fail++; $display("FAIL err_set: got %b/%0d expected 1/2", credit_err, mem_credits); end
        step();
        n_cmp++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", credit_err); end
    endtask

    task automatic test_random();
        logic [3:0] busy;
        for (int c = 0; c < 400; c++) begin
            busy = m_alu | m_mem;
            for (int i = 0; i < 4; i++) begin
                if (!oc_ready[i] && !busy[i] && $urandom_range(0, 2) == 0) begin
                    oc_ready[i] = 1'b1;
                    oc_ismem[i] = 1'($urandom_range(0, 1));
                end
            end
            alu_stall = ($urandom_range(0, 3) == 0);
            mem_done  = (m_cred < MEM_CREDITS) && ($urandom_range(0, 1) == 1);
            step();
            n_cmp++; if (alu_grt !== m_alu) begin n_fail++; $display("FAIL rnd_alu@%0d: got %b expected %b", c, alu_grt, m_alu); end
            n_cmp++; if (mem_grt !== m_mem) begin n_fail++; $display("FAIL rnd_mem@%0d: got %b expected %b", c, mem_grt, m_mem); end
            n_cmp++; if (oc_release !== (m_alu | m_mem)) begin n_fail++; $display("FAIL rnd_rel@%0d: got %b expected %b", c, oc_release, m_alu | m_mem); end
            n_cmp++; if (mem_credits !== 2'(m_cred)) begin n_fail++; $display("FAIL rnd_cred@%0d: got %0d expected %0d", c, mem_credits, m_cred); end
            n_cmp++; if (credit_err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b expected %b", c, credit_err, m_err); end
            retire();
        end
        oc_ready = '0; alu_stall = 1'b0; mem_done = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        oc_ready = 4'b1111; oc_ismem = 4'b1010; alu_stall = 1'b0; mem_done = 1'b0;
        step();
        n_cmp++; if (alu_grt !== m_alu || mem_grt !== m_mem || m_mem == 4'b0) begin n_fail++; $display("FAIL mid_pre: got %b/%b expected %b/%b", alu_grt, mem_grt, m_alu, m_mem); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (alu_grt !== 4'b0 || mem_grt !== 4'b0 || oc_release !== 4'b0) begin n_fail++; $display("FAIL mid_grt: got %b/%b/%b expected 0", alu_grt, mem_grt, oc_release); end
        n_cmp++; if (mem_credits !== 2'd2 || credit_err !== 1'b0) begin n_fail++; $display("FAIL mid_cred: got %0d/%b expected 2/0", mem_credits, credit_err); end
        model_reset();
        oc_ready = '0; oc_ismem = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        n_cmp++; if ((alu_grt | mem_grt) !== 4'b0 || mem_credits !== 2'd2) begin n_fail++; $display("FAIL mid_after: got %b/%b/%0d expected 0/0/2", alu_grt, mem_grt, mem_credits); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu_rotation();
        test_alu_mem_pair();
        test_mem_credits();
        test_alu_stall();
        test_credit_err();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
